control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Multicycle next-state engine for the processor control unit. It sits directly upstream of the control decode stage.
- Each cycle it registers a 4-bit `state` code from the current state and the instruction opcode. The decode stage turns that code into datapath strobes.
- It also produces a halted/illegal-opcode status and two performance counters: cycles and retired instructions.

Parameters:
- CNT_W, 32, width of cycleCount and instrCount.
- RESET_STATE, 4'd0, state loaded at reset. Must remain INSTRUCTION_FETCH; exists only for bench override.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- opcode  in  6  instruction register opcode field. Valid from REGISTER_FETCH onward; IR is written at the end of INSTRUCTION_FETCH.
- state  out  4  registered current state, consumed by the control decode stage.
- halted  out  1  high while in HALT.
- illegalOp  out  1  sticky; set on entry to ERROR.
- cycleCount  out  CNT_W  clocks since reset, excluding HALT/ERROR.
- instrCount  out  CNT_W  retired instructions.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n). All outputs are registered.
- Reset values (rst_n=0 at a rising edge): state=INSTRUCTION_FETCH(0), halted=0, illegalOp=0, cycleCount=0, instrCount=0. Reset mid-instruction aborts it; nothing retires.
- State encoding: INSTRUCTION_FETCH=0, REGISTER_FETCH=1, IMMEDIATE_INJECTION2=2, ALU_R3=3, ALU_RI3=4, ALU4=5, BRANCH3=6, MEMORY_REF3=7, LOAD4=8, STORE4=9, LOAD5=10, JUMP3=11, HALT=12, ERROR=13. Codes 14–15 are unreachable; if present, go to ERROR.
- Opcode classes, decoded in REGISTER_FETCH only:
  - opcode[5:4]=00: R-type ALU.
  - opcode[5:4]=01: RI-type ALU.
  - opcode[5:4]=10: branch.
  - opcode[5:4]=11: opcode[3:0] selects 0000 load, 0001 store, 0010 jump, 0011 load-immediate, 1111 halt; any other value is illegal.
- Transitions (one per clock):
  - INSTRUCTION_FETCH -> REGISTER_FETCH, unconditional.
  - REGISTER_FETCH -> by class: R-type ALU_R3; RI-type ALU_RI3; branch BRANCH3; load/store MEMORY_REF3; jump JUMP3; load-immediate IMMEDIATE_INJECTION2; halt HALT; illegal ERROR.
  - ALU_R3 and ALU_RI3 -> ALU4.
  - MEMORY_REF3 -> LOAD4 if opcode[0]=0, else STORE4. Uses the same opcode; the IR is stable across the instruction.
  - LOAD4 -> LOAD5.
  - Terminal states -> INSTRUCTION_FETCH: IMMEDIATE_INJECTION2, ALU4, BRANCH3, STORE4, LOAD5, JUMP3.
  - HALT and ERROR are absorbing; only reset leaves them.
  - HALT/ERROR are entered only from REGISTER_FETCH. The decode stage therefore holds REGISTER_FETCH strobes (no PC, IR or register writes) while stopped.
- Latency per instruction, in cycles: load-immediate 3, branch 3, jump 3, R/RI ALU 4, store 4, load 5.
- Counters:
  - cycleCount increments every clock whose current state is not HALT/ERROR.
  - instrCount increments on every clock whose current state is a terminal state, i.e. the transition back to INSTRUCTION_FETCH.
  - Halt does not retire. Both counters wrap modulo 2^CNT_W silently.
- Status flags:
  - halted=1 registered with entry to HALT.
  - illegalOp=1 registered with entry to ERROR; it stays set until reset.
  - halted and illegalOp are never both 1.
- Opcode values are don't-care in every state except REGISTER_FETCH and MEMORY_REF3.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks with opcode=6'h3F -> state=0, all counters and flags 0; first release clock -> state=1.
- R-type: opcode=6'h02 from reset release -> states 0,1,3,5,0; instrCount=1 at cycleCount=4.
- Mixed program: load (6'h30), store (6'h31), branch (6'h24), jump (6'h32), load-immediate (6'h33) -> sequences 0,1,7,8,10 / 0,1,7,9 / 0,1,6 / 0,1,11 / 0,1,2; instrCount=5, cycleCount=18.
- Halt: RI op (6'h11) then 6'h3F -> state reaches 12, halted=1; after 10 further clocks state=12, cycleCount frozen at 6, instrCount=1.
- Illegal: opcode=6'h35 in REGISTER_FETCH -> state=13, illegalOp=1, instrCount unchanged; rst_n=0 one clock -> state=0, illegalOp=0.
- Reset mid-load: rst_n=0 while state=8 -> next state=0, instrCount=0; wrap check with CNT_W=4 -> 16 retirements give instrCount=0.

Source files
------------

// File: rtl/control_sequencer.sv
// Multicycle next-state engine for the processor control unit: registered state code,
// halted/illegal-opcode status, and cycle / retired-instruction counters.
module control_sequencer #(
    parameter int         CNT_W       = 32,
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    output logic [3:0]       state,
    output logic             halted,
    output logic             illegalOp,
    output logic [CNT_W-1:0] cycleCount,
    output logic [CNT_W-1:0] instrCount
);

    // state                | meaning
    // INSTRUCTION_FETCH    | fetch, IR written at end of cycle
    // REGISTER_FETCH       | register read, opcode class decoded
    // IMMEDIATE_INJECTION2 | load-immediate writeback (terminal)
    // ALU_R3 / ALU_RI3     | ALU execute, register / immediate operand
    // ALU4                 | ALU writeback (terminal)
    // BRANCH3              | branch compare and PC update (terminal)
    // MEMORY_REF3          | address compute, opcode[0] picks load/store
    // LOAD4 / LOAD5        | memory read / register writeback (terminal)
    // STORE4               | memory write (terminal)
    // JUMP3                | PC update (terminal)
    // HALT / ERROR         | absorbing until reset
    typedef enum logic [3:0] {
        INSTRUCTION_FETCH    = 4'd0,
        REGISTER_FETCH       = 4'd1,
        IMMEDIATE_INJECTION2 = 4'd2,
        ALU_R3               = 4'd3,
        ALU_RI3              = 4'd4,
        ALU4                 = 4'd5,
        BRANCH3              = 4'd6,
        MEMORY_REF3          = 4'd7,
        LOAD4                = 4'd8,
        STORE4               = 4'd9,
        LOAD5                = 4'd10,
        JUMP3                = 4'd11,
        HALT                 = 4'd12,
        ERROR                = 4'd13
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state;
    logic             r_halted;
    logic             r_illegal;
    logic [CNT_W-1:0] r_cycle;
    logic [CNT_W-1:0] r_instr;

    state_t w_next;
    logic   w_retire;
    logic   w_stopped;

    always_comb begin
        w_next = ERROR;
        case (r_state)
            INSTRUCTION_FETCH: w_next = REGISTER_FETCH;
            REGISTER_FETCH: begin
                case (opcode[5:4])
                    2'b00: w_next = ALU_R3;
                    2'b01: w_next = ALU_RI3;
                    2'b10: w_next = BRANCH3;
                    default: begin
                        case (opcode[3:0])
                            4'b0000, 4'b0001: w_next = MEMORY_REF3;
                            4'b0010:          w_next = JUMP3;
                            4'b0011:          w_next = IMMEDIATE_INJECTION2;
                            4'b1111:          w_next = HALT;
                            default:          w_next = ERROR;
                        endcase
                    end
                endcase
            end
            ALU_R3, ALU_RI3: w_next = ALU4;
            MEMORY_REF3:     w_next = opcode[0] ? STORE4 : LOAD4;
            LOAD4:           w_next = LOAD5;
            IMMEDIATE_INJECTION2, ALU4, BRANCH3, STORE4, LOAD5, JUMP3:
                             w_next = INSTRUCTION_FETCH;
            HALT:            w_next = HALT;
            default:         w_next = ERROR;
        endcase
    end

    assign w_retire  = (r_state == IMMEDIATE_INJECTION2) || (r_state == ALU4) ||
                       (r_state == BRANCH3) || (r_state == STORE4) ||
                       (r_state == LOAD5) || (r_state == JUMP3);
    // Unreachable codes 14/15 still count as running until they fall into ERROR.
    assign w_stopped = (r_state == HALT) || (r_state == ERROR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= state_t'(RESET_STATE);
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
            r_cycle   <= '0;
            r_instr   <= '0;
        end else begin
            r_state  <= w_next;
            r_halted <= (w_next == HALT);
            if (w_next == ERROR)
                r_illegal <= 1'b1;
            if (!w_stopped)
                r_cycle <= r_cycle + CNT_ONE;
            if (w_retire)
                r_instr <= r_instr + CNT_ONE;
        end
    end

    assign state      = r_state;
    assign halted     = r_halted;
    assign illegalOp  = r_illegal;
    assign cycleCount = r_cycle;
    assign instrCount = r_instr;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: state sequences, counters, halt/error
// handling, reset abort, narrow-counter wrap and the unreachable-code recovery.
module tb_control_sequencer;

    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;

    logic [3:0]  state;
    logic        halted;
    logic        illegalOp;
    logic [31:0] cycleCount;
    logic [31:0] instrCount;

    logic [3:0]  n_state;
    logic        n_halted;
    logic        n_illegal;
    logic [3:0]  n_cycle;
    logic [3:0]  n_instr;

    logic [3:0]  b_state;
    logic        b_halted;
    logic        b_illegal;
    logic [31:0] b_cycle;
    logic [31:0] b_instr;

    int n_cmp = 0;
    int n_bad = 0;

    control_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .state(state), .halted(halted),
        .illegalOp(illegalOp), .cycleCount(cycleCount), .instrCount(instrCount)
    );

    control_sequencer #(.CNT_W(4)) u_narrow (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .state(n_state), .halted(n_halted),
        .illegalOp(n_illegal), .cycleCount(n_cycle), .instrCount(n_instr)
    );

    control_sequencer #(.RESET_STATE(4'd14)) u_bad (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .state(b_state), .halted(b_halted),
        .illegalOp(b_illegal), .cycleCount(b_cycle), .instrCount(b_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // seq holds the expected state codes, first in bits [3:0]
    task automatic run_op(input string tag, input logic [5:0] op, input int len,
                          input logic [19:0] seq);
        opcode = op;
        for (int i = 0; i < len; i++) begin
            chk($sformatf("%s_s%0d", tag, i), 64'(state), 64'(seq[i*4 +: 4]));
            tick();
        end
        chk($sformatf("%s_end", tag), 64'(state), 64'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        opcode = 6'h3F;

        tick();
        tick();
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_illegal", 64'(illegalOp), 64'd0);
        chk("rst_cycle", 64'(cycleCount), 64'd0);
        chk("rst_instr", 64'(instrCount), 64'd0);
        chk("bad_rst_state", 64'(b_state), 64'd14);

        opcode = 6'h02;
        rst_n  = 1'b1;
        tick();
        chk("rel_state", 64'(state), 64'd1);
        chk("bad_to_error", 64'(b_state), 64'd13);
        chk("bad_illegal", 64'(b_illegal), 64'd1);
        chk("bad_cycle", 64'(b_cycle), 64'd1);

        // R-type from release: 0,1,3,5,0
        do_reset();
        run_op("rtype", 6'h02, 4, {4'd0, 4'd5, 4'd3, 4'd1, 4'd0});
        chk("rtype_instr", 64'(instrCount), 64'd1);
        chk("rtype_cycle", 64'(cycleCount), 64'd4);
        chk("bad_absorb", 64'(b_state), 64'd13);

        do_reset();
        run_op("load",  6'h30, 5, {4'd10, 4'd8, 4'd7, 4'd1, 4'd0});
        run_op("store", 6'h31, 4, {4'd0, 4'd9, 4'd7, 4'd1, 4'd0});
        run_op("bra",   6'h24, 3, {4'd0, 4'd0, 4'd6, 4'd1, 4'd0});
        run_op("jump",  6'h32, 3, {4'd0, 4'd0, 4'd11, 4'd1, 4'd0});
        run_op("limm",  6'h33, 3, {4'd0, 4'd0, 4'd2, 4'd1, 4'd0});
        chk("mix_instr", 64'(instrCount), 64'd5);
        chk("mix_cycle", 64'(cycleCount), 64'd18);

        do_reset();
        run_op("ri", 6'h11, 4, {4'd0, 4'd5, 4'd4, 4'd1, 4'd0});
        opcode = 6'h3F;
        tick();
        tick();
        chk("halt_state", 64'(state), 64'd12);
        chk("halt_flag", 64'(halted), 64'd1);
        chk("halt_noillegal", 64'(illegalOp), 64'd0);
        repeat (10) tick();
        chk("halt_hold", 64'(state), 64'd12);
        chk("halt_cycle", 64'(cycleCount), 64'd6);
        chk("halt_instr", 64'(instrCount), 64'd1);
        chk("halt_flag_hold", 64'(halted), 64'd1);

        do_reset();
        opcode = 6'h35;
        tick();
        tick();
        chk("ill_state", 64'(state), 64'd13);
        chk("ill_flag", 64'(illegalOp), 64'd1);
        chk("ill_nohalt", 64'(halted), 64'd0);
        chk("ill_instr", 64'(instrCount), 64'd0);
        tick();
        chk("ill_hold", 64'(state), 64'd13);
        chk("ill_cycle", 64'(cycleCount), 64'd2);
        rst_n = 1'b0;
        tick();
        chk("ill_rst_state", 64'(state), 64'd0);
        chk("ill_rst_flag", 64'(illegalOp), 64'd0);
        rst_n = 1'b1;

        // Reset in LOAD4 aborts the load without retiring it
        run_op("pre", 6'h02, 4, {4'd0, 4'd5, 4'd3, 4'd1, 4'd0});
        chk("pre_instr", 64'(instrCount), 64'd1);
        opcode = 6'h30;
        repeat (3) tick();
        chk("midload_state", 64'(state), 64'd8);
        rst_n = 1'b0;
        tick();
        chk("midload_rst_state", 64'(state), 64'd0);
        chk("midload_rst_instr", 64'(instrCount), 64'd0);
        chk("midload_rst_cycle", 64'(cycleCount), 64'd0);
        rst_n = 1'b1;

        // 16 jumps: 16 retirements, 48 cycles; 4-bit counters wrap to 0
        for (int k = 0; k < 16; k++)
            run_op("wrapj", 6'h32, 3, {4'd0, 4'd0, 4'd11, 4'd1, 4'd0});
        chk("wrap_narrow_instr", 64'(n_instr), 64'd0);
        chk("wrap_narrow_cycle", 64'(n_cycle), 64'd0);
        chk("wrap_wide_instr", 64'(instrCount), 64'd16);
        chk("wrap_wide_cycle", 64'(cycleCount), 64'd48);
        chk("wrap_narrow_state", 64'(n_state), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
